// File: rtl/pong_pkg.sv
// Shared constants for the Pong game logic and its support primitives.
package pong_pkg;

    // Coordinate and random-number widths
    localparam int unsigned X_POS_W   = 10;
    localparam int unsigned Y_POS_W   = 10;
    localparam int unsigned RND_NUM_W = 9;

    // Screen geometry (640x480 visible area)
    localparam int unsigned H_RES     = 640;
    localparam int unsigned V_RES     = 480;
    localparam int unsigned BORDER    = 8;

    // Sprite geometry
    localparam int unsigned PADDLE_W  = 8;
    localparam int unsigned PADDLE_H  = 48;
    localparam int unsigned BALL_SIDE = 8;

    // Movement speeds in pixels per strobe
    localparam int unsigned PC_SPEED     = 1;
    localparam int unsigned PLAYER_SPEED = 2;

    // LFSR defaults: x^9 + x^5 + 1, maximal length 511
    localparam logic [RND_NUM_W-1:0] LFSR_TAPS = RND_NUM_W'('h110);
    localparam logic [RND_NUM_W-1:0] LFSR_SEED = RND_NUM_W'('h001);

    // Strobe period in clock cycles
    function automatic int unsigned strobe_period(input int unsigned clk_hz,
                                                  input int unsigned strobe_hz);
        return clk_hz / strobe_hz;
    endfunction

endpackage

// File: rtl/pong_prims_if.sv
// Rectangle-pair bus feeding the collision detector and carrying its result back.
interface pong_prims_if #(
    parameter int unsigned X_W = pong_pkg::X_POS_W,
    parameter int unsigned Y_W = pong_pkg::Y_POS_W
);
    logic [X_W-1:0] r1_left_i;
    logic [X_W-1:0] r1_right_i;
    logic [Y_W-1:0] r1_top_i;
    logic [Y_W-1:0] r1_bottom_i;
    logic [X_W-1:0] r2_left_i;
    logic [X_W-1:0] r2_right_i;
    logic [Y_W-1:0] r2_top_i;
    logic [Y_W-1:0] r2_bottom_i;
    logic           collision_o;

    modport master (
        output r1_left_i, r1_right_i, r1_top_i, r1_bottom_i,
        output r2_left_i, r2_right_i, r2_top_i, r2_bottom_i,
        input  collision_o
    );

    modport slave (
        input  r1_left_i, r1_right_i, r1_top_i, r1_bottom_i,
        input  r2_left_i, r2_right_i, r2_top_i, r2_bottom_i,
        output collision_o
    );
endinterface

// File: rtl/random.sv
// Free-running Fibonacci LFSR; shifts left every cycle, feedback into bit 0.
module random
    import pong_pkg::*;
#(
    parameter int unsigned      RND_W = RND_NUM_W,
    parameter logic [RND_W-1:0] TAPS  = RND_W'(LFSR_TAPS),
    parameter logic [RND_W-1:0] SEED  = RND_W'(LFSR_SEED)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [RND_W-1:0] rnd_num_o
);
    logic [RND_W-1:0] r_lfsr;
    logic             w_fb;

    // XOR of the tapped bits
    assign w_fb = ^(r_lfsr & TAPS);

    // LFSR state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[RND_W-2:0], w_fb};
        end
    end

    assign rnd_num_o = r_lfsr;
endmodule

// File: rtl/sprite_collision.sv
// Registered overlap test of two half-open rectangles; degenerate rectangles never hit.
module sprite_collision
    import pong_pkg::*;
#(
    parameter int unsigned X_W = X_POS_W,
    parameter int unsigned Y_W = Y_POS_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [X_W-1:0] r1_left_i,
    input  logic [X_W-1:0] r1_right_i,
    input  logic [Y_W-1:0] r1_top_i,
    input  logic [Y_W-1:0] r1_bottom_i,
    input  logic [X_W-1:0] r2_left_i,
    input  logic [X_W-1:0] r2_right_i,
    input  logic [Y_W-1:0] r2_top_i,
    input  logic [Y_W-1:0] r2_bottom_i,
    output logic           collision_o
);
    logic w_r1_valid;
    logic w_r2_valid;
    logic w_overlap;
    logic r_collision;

    // A zero-area rectangle is excluded explicitly; the strict overlap terms alone would
    // still report a zero-width span lying inside the other rectangle.
    assign w_r1_valid = (r1_right_i > r1_left_i) && (r1_bottom_i > r1_top_i);
    assign w_r2_valid = (r2_right_i > r2_left_i) && (r2_bottom_i > r2_top_i);

    // Strict compares keep edges exclusive: touching rectangles do not overlap
    assign w_overlap = (r1_left_i < r2_right_i) && (r1_right_i > r2_left_i) &&
                       (r1_top_i < r2_bottom_i) && (r1_bottom_i > r2_top_i);

    // One-cycle registered result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_overlap && w_r1_valid && w_r2_valid;
        end
    end

    assign collision_o = r_collision;
endmodule

// File: rtl/strobe_gen.sv
// Periodic one-cycle strobe: high while the phase counter holds PERIOD-1.
module strobe_gen
    import pong_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned STROBE_FREQ_HZ = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic strobe_o
);
    localparam int unsigned PERIOD = strobe_period(CLK_FREQ_HZ, STROBE_FREQ_HZ);
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_strobe;
    logic             w_last;
    logic             w_pre_last;

    // Strobe is registered from the cycle before the wrap so it lines up with count PERIOD-1
    assign w_last     = (r_cnt == CNT_W'(PERIOD - 1));
    assign w_pre_last = (r_cnt == CNT_W'(PERIOD - 2));

    // Phase counter and registered strobe
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
            r_strobe <= w_pre_last;
        end
    end

    assign strobe_o = r_strobe;
endmodule

// File: rtl/pong_prims.sv
// Pong support primitives: speed strobe, random source and collision detector.
module pong_prims
    import pong_pkg::*;
#(
    parameter int unsigned      CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned      STROBE_FREQ_HZ = 100,
    parameter int unsigned      RND_W          = RND_NUM_W,
    parameter logic [RND_W-1:0] TAPS           = RND_W'('h110),
    parameter logic [RND_W-1:0] SEED           = RND_W'('h001),
    parameter int unsigned      X_W            = X_POS_W,
    parameter int unsigned      Y_W            = Y_POS_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pong_prims_if.slave      bus,
    output logic             strobe_o,
    output logic [RND_W-1:0] rnd_num_o
);
    logic w_collision;

    strobe_gen #(
        .CLK_FREQ_HZ   (CLK_FREQ_HZ),
        .STROBE_FREQ_HZ(STROBE_FREQ_HZ)
    ) u_strobe_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .strobe_o(strobe_o)
    );

    random #(
        .RND_W(RND_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_random (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rnd_num_o(rnd_num_o)
    );

    sprite_collision #(
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_sprite_collision (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .r1_left_i  (bus.r1_left_i),
        .r1_right_i (bus.r1_right_i),
        .r1_top_i   (bus.r1_top_i),
        .r1_bottom_i(bus.r1_bottom_i),
        .r2_left_i  (bus.r2_left_i),
        .r2_right_i (bus.r2_right_i),
        .r2_top_i   (bus.r2_top_i),
        .r2_bottom_i(bus.r2_bottom_i),
        .collision_o(w_collision)
    );

    assign bus.collision_o = w_collision;
endmodule

// File: tb/tb_pong_prims.sv
// Scoreboard bench for pong_prims: driver queues cycle-tagged expectations, monitor checks them.
module tb_pong_prims;

    localparam int unsigned K_STROBE  = 0;
    localparam int unsigned K_RND     = 1;
    localparam int unsigned K_COLL    = 2;
    localparam int unsigned K_NONZERO = 3;

    typedef struct {
        int unsigned cyc;
        int unsigned kind;
        logic [8:0]  val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strobe;
    logic [8:0] rnd;

    exp_t        sb_q[$];
    int unsigned cyc_cnt = 0;
    int unsigned n_cmp   = 0;
    int unsigned n_bad   = 0;

    pong_prims_if #(.X_W(10), .Y_W(10)) u_if ();

    pong_prims #(
        .CLK_FREQ_HZ   (10),
        .STROBE_FREQ_HZ(2),
        .RND_W         (9),
        .TAPS          (9'h110),
        .SEED          (9'h001),
        .X_W           (10),
        .Y_W           (10)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .bus      (u_if),
        .strobe_o (strobe),
        .rnd_num_o(rnd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Collision vectors: r1 l,r,t,b ; r2 l,r,t,b ; expected
    int unsigned vec [0:9][0:8] = '{
        '{620, 630, 220, 260, 615, 623, 230, 238, 1},
        '{620, 630, 220, 260, 630, 638, 230, 238, 0},
        '{620, 630, 220, 221, 622, 630, 213, 221, 1},
        '{620, 630, 220, 221, 622, 630, 221, 229, 0},
        '{100, 100,  10,  50,  50, 150,   0, 100, 0},
        '{  0, 639,   0, 479,  10,  20,  30,  25, 0},
        '{  0, 639,   0, 479,  10,  20,  30,  40, 1},
        '{100, 200, 100, 200, 150, 160, 200, 210, 0},
        '{100, 200, 100, 200, 150, 160, 199, 210, 1},
        '{620, 630, 220, 260, 615, 623, 230, 238, 1}
    };

    logic [8:0] lfsr_seq [0:6] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h021, 9'h042};

    function automatic string kind_name(input int unsigned k);
        case (k)
            K_STROBE:  return "strobe_o";
            K_RND:     return "rnd_num_o";
            K_COLL:    return "collision_o";
            default:   return "rnd_nonzero";
        endcase
    endfunction

    task automatic check(input string nm, input int unsigned kind, input logic [8:0] act,
                         input logic [8:0] req);
        logic ok;
        n_cmp = n_cmp + 1;
        ok = (kind == K_NONZERO) ? (act != 9'd0) : (act === req);
        if (!ok) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @t=%0t: actual=0x%0h required=%s0x%0h", nm, $time, act,
                     (kind == K_NONZERO) ? "nonzero, not " : "", req);
        end
    endtask

    function automatic logic [8:0] sample(input int unsigned kind);
        case (kind)
            K_STROBE: return {8'd0, strobe};
            K_COLL:   return {8'd0, u_if.collision_o};
            default:  return rnd;
        endcase
    endfunction

    task automatic push(input int unsigned c, input int unsigned kind, input logic [8:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic drive(input int unsigned idx);
        u_if.r1_left_i   = 10'(vec[idx][0]);
        u_if.r1_right_i  = 10'(vec[idx][1]);
        u_if.r1_top_i    = 10'(vec[idx][2]);
        u_if.r1_bottom_i = 10'(vec[idx][3]);
        u_if.r2_left_i   = 10'(vec[idx][4]);
        u_if.r2_right_i  = 10'(vec[idx][5]);
        u_if.r2_top_i    = 10'(vec[idx][6]);
        u_if.r2_bottom_i = 10'(vec[idx][7]);
    endtask

    // Monitor: shortly after each falling edge, compare every expectation due this cycle
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc == cyc_cnt) begin
                    check(kind_name(sb_q[i].kind), sb_q[i].kind, sample(sb_q[i].kind),
                          sb_q[i].val);
                    sb_q.delete(i);
                end
            end
        end
    end

    // Driver / stimulus
    initial begin
        int unsigned c0;
        int unsigned c1;
        rst_n = 1'b0;
        u_if.r1_left_i   = '0;
        u_if.r1_right_i  = '0;
        u_if.r1_top_i    = '0;
        u_if.r1_bottom_i = '0;
        u_if.r2_left_i   = '0;
        u_if.r2_right_i  = '0;
        u_if.r2_top_i    = '0;
        u_if.r2_bottom_i = '0;

        repeat (3) @(negedge clk);
        push(cyc_cnt, K_STROBE, 9'd0);
        push(cyc_cnt, K_RND,    9'h001);
        push(cyc_cnt, K_COLL,   9'd0);

        // Release; cycle k after release is observed at cyc_cnt == c0 + k - 1
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc_cnt;
        for (int k = 1; k <= 16; k++)
            push(c0 + 32'(k) - 1, K_STROBE, (k % 5 == 0) ? 9'd1 : 9'd0);
        for (int k = 1; k <= 7; k++)
            push(c0 + 32'(k) - 1, K_RND, lfsr_seq[k-1]);
        for (int k = 1; k <= 511; k++)
            push(c0 + 32'(k) - 1, K_NONZERO, 9'd0);
        push(c0 + 511, K_RND, 9'h001);
        push(c0, K_COLL, 9'd0);

        // Collision vectors, one per cycle, result due one cycle later
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            drive(v);
            push(cyc_cnt + 1, K_COLL, 9'(vec[v][8]));
        end

        // Hold overlap until mid strobe period well past the LFSR wrap
        while (cyc_cnt < c0 + 516) @(negedge clk);
        push(cyc_cnt, K_COLL, 9'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_strobe", K_STROBE, {8'd0, strobe}, 9'd0);
        check("async_rnd",    K_RND,    rnd,             9'h001);
        check("async_coll",   K_COLL,   {8'd0, u_if.collision_o}, 9'd0);

        // Release again; strobe phase restarts, collision re-registers
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c1 = cyc_cnt;
        for (int k = 1; k <= 11; k++)
            push(c1 + 32'(k) - 1, K_STROBE, (k % 5 == 0) ? 9'd1 : 9'd0);
        for (int k = 1; k <= 3; k++)
            push(c1 + 32'(k) - 1, K_RND, lfsr_seq[k-1]);
        push(c1,     K_COLL, 9'd0);
        push(c1 + 1, K_COLL, 9'd1);

        while (cyc_cnt < c1 + 13) @(negedge clk);
        #3;
        foreach (sb_q[i]) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s unchecked: expected 0x%0h at cycle %0d never compared",
                     kind_name(sb_q[i].kind), sb_q[i].val, sb_q[i].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
